fp_mul_pipe: RTL
================

FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 8, exponent field width (4..11).
REQ-002 The block SHALL have parameter MAN_W, default 23, stored fraction width (4..52).
REQ-003 The block SHALL use derived width DW = 1+EXP_W+MAN_W, with fields {sign, exponent, fraction} from MSB to LSB.
REQ-004 Port: clock  in  1  single clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: s_axis_a_tvalid  in  1  / s_axis_a_tready  out  1  / s_axis_a_tdata  in  DW  operand A stream.
REQ-007 Port: s_axis_b_tvalid  in  1  / s_axis_b_tready  out  1  / s_axis_b_tdata  in  DW  operand B stream.
REQ-008 Port: m_axis_result_tvalid  out  1  / m_axis_result_tready  in  1  / m_axis_result_tdata  out  DW  product stream.
REQ-009 Port: m_axis_result_tuser  out  4  flags {invalid, overflow, underflow, inexact}, aligned with tdata.

Function
REQ-010 The pipeline SHALL have 3 registered stages (S1 unpack/classify/mantissa product, S2 normalise/round, S3 special-case select/pack), each with its own valid bit.
REQ-011 The global advance signal SHALL be adv = !m_axis_result_tvalid || m_axis_result_tready; when adv=0, every stage register and valid SHALL hold.
REQ-012 The ready outputs SHALL be s_axis_a_tready = adv && s_axis_b_tvalid and s_axis_b_tready = adv && s_axis_a_tvalid, so A and B always transfer on the same cycle.
REQ-013 An operand pair SHALL be accepted only when adv && both tvalid; S1 valid SHALL load that condition whenever adv=1, so bubbles propagate and are not collapsed.
REQ-014 Latency SHALL be exactly 3 cycles from accept edge to m_axis_result_tvalid high when unstalled; throughput SHALL be one result per cycle.
REQ-015 Results SHALL emerge in acceptance order, and tdata/tuser SHALL remain stable while tvalid=1 and tready=0.
REQ-016 Result sign SHALL be signA XOR signB in all cases except NaN.
REQ-017 Subnormal inputs SHALL be treated as signed zero (DAZ) with no flag.
REQ-018 Normal x normal: the (MAN_W+1)x(MAN_W+1) product SHALL be normalised by at most 1-bit right shift, the exponent SHALL be expA+expB-bias (+1 on shift) computed at EXP_W+2 bits signed, and rounding SHALL be round-to-nearest-even using guard and sticky bits.
REQ-019 Rounding carry-out SHALL renormalise the result (exponent+1, fraction 0).
REQ-020 If the final exponent is at or above the all-ones value, the output SHALL be signed infinity with overflow=1 and inexact=1.
REQ-021 If the final exponent is at or below 0, the output SHALL be signed zero (FTZ) with underflow=1 and inexact=1.
REQ-022 inexact SHALL be set whenever discarded guard/sticky bits are nonzero.
REQ-023 If either input is NaN, the output SHALL be the canonical quiet NaN {0, all-ones exponent, fraction MSB=1, rest 0}; invalid SHALL be set if either NaN is signalling (fraction MSB=0).
REQ-024 inf x zero SHALL give canonical NaN with invalid=1.
REQ-025 inf x finite-nonzero or inf x inf SHALL give signed infinity with no flags.
REQ-026 zero x finite SHALL give signed zero with no flags.
REQ-027 Flags SHALL be 0 for all exact normal results.

Reset
REQ-028 When rst=1 at a clock edge, all stage valids, m_axis_result_tvalid, m_axis_result_tdata and m_axis_result_tuser SHALL clear to 0.
REQ-029 s_axis_a_tready and s_axis_b_tready SHALL be 0 while rst=1.
REQ-030 In-flight operands SHALL be discarded on reset mid-operation, and no result SHALL appear for them after rst deasserts.
REQ-031 The first pair offered after rst deasserts SHALL be accepted on the next edge, producing its result 3 cycles later.

Verification
REQ-032 Default params: A=0x3FC00000, B=0x40000000, tready=1 -> tdata=0x40400000, tuser=0, tvalid exactly 3 cycles after accept.
REQ-033 Streaming 8 pairs back-to-back with tready toggling 1,0,0,1,... -> all 8 products in order, none dropped or duplicated, tdata stable during stall, 8 tready-gated acceptances.
REQ-034 Specials: 0x7F800000 x 0x00000000 -> 0x7FC00000, tuser=1000; 0x7F800001 x 0x3F800000 -> 0x7FC00000, tuser=1000; 0xFF800000 x 0x40000000 -> 0xFF800000, tuser=0000.
REQ-035 Range: 0x7F7FFFFF x 0x40000000 -> 0x7F800000, tuser=0101; 0x00800000 x 0x3F000000 -> 0x00000000, tuser=0011; 0x00000001 x 0x3F800000 -> 0x00000000, tuser=0000.
REQ-036 Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002, tuser=0001; 0x3FFFFFFF x 0x3FFFFFFF -> 0x407FFFFE, tuser=0001.
REQ-037 Pulse rst one cycle with 2 pairs in flight -> tvalid=0 the following cycle, no stale results, then 0x40400000 x 0x3F800000 -> 0x40400000 three cycles after accept; repeat with EXP_W=5, MAN_W=10: 0x3C00 x 0x4000 -> 0x4000.

Source files
------------

// File: rtl/fp_mul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_pipe
//  Purpose  : Three-stage pipelined floating-point multiplier with AXI-Stream
//             style operand/result handshakes. Subnormal inputs are treated
//             as zero (DAZ), tiny results are flushed to zero (FTZ), and
//             rounding is round-to-nearest-even.
//
//  Ports    : clock                 single rising-edge clock
//             rst                   synchronous active-high reset
//             s_axis_a_*            operand A stream (tvalid/tready/tdata)
//             s_axis_b_*            operand B stream (tvalid/tready/tdata)
//             m_axis_result_*       product stream (tvalid/tready/tdata)
//             m_axis_result_tuser   {invalid, overflow, underflow, inexact}
//
//  Revision : 1.0  initial release
// ============================================================================
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 s_axis_a_tvalid,
  output logic                 s_axis_a_tready,
  input  logic [EXP_W+MAN_W:0] s_axis_a_tdata,
  input  logic                 s_axis_b_tvalid,
  output logic                 s_axis_b_tready,
  input  logic [EXP_W+MAN_W:0] s_axis_b_tdata,
  output logic                 m_axis_result_tvalid,
  input  logic                 m_axis_result_tready,
  output logic [EXP_W+MAN_W:0] m_axis_result_tdata,
  output logic [3:0]           m_axis_result_tuser
);

  localparam int C_DW = 1 + EXP_W + MAN_W;
  localparam int C_PW = 2 * MAN_W + 2;   // full mantissa product width
  localparam int C_EW = EXP_W + 2;       // exponent working width (signed)
  localparam logic [C_EW-1:0] C_BIAS     = C_EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [C_EW-2:0] C_EXP_ONES = {1'b0, {EXP_W{1'b1}}};

  // --------------------------------------------------------------------------
  // Handshake: the whole pipe moves together whenever the output slot is free
  // or being drained. A and B readies each depend on the other's valid so that
  // both operands always transfer on the same edge.
  // --------------------------------------------------------------------------
  logic w_adv;
  logic w_accept;

  assign w_adv           = !m_axis_result_tvalid || m_axis_result_tready;
  assign w_accept        = w_adv && s_axis_a_tvalid && s_axis_b_tvalid;
  assign s_axis_a_tready = !rst && w_adv && s_axis_b_tvalid;
  assign s_axis_b_tready = !rst && w_adv && s_axis_a_tvalid;

  // --------------------------------------------------------------------------
  // Stage 1 combinational: unpack, classify, exponent sum, mantissa product
  // --------------------------------------------------------------------------
  logic             w_sign_a, w_sign_b;
  logic [EXP_W-1:0] w_exp_a, w_exp_b;
  logic [MAN_W-1:0] w_frac_a, w_frac_b;
  logic             w_zero_a, w_zero_b, w_inf_a, w_inf_b;
  logic             w_nan_a, w_nan_b, w_snan_a, w_snan_b;
  logic             w_inf_zero;
  logic             w_nan, w_invalid, w_inf, w_zero;
  logic [C_EW-1:0]  w_exp_sum;
  logic [C_PW-1:0]  w_prod;

  assign w_sign_a = s_axis_a_tdata[C_DW-1];
  assign w_sign_b = s_axis_b_tdata[C_DW-1];
  assign w_exp_a  = s_axis_a_tdata[C_DW-2:MAN_W];
  assign w_exp_b  = s_axis_b_tdata[C_DW-2:MAN_W];
  assign w_frac_a = s_axis_a_tdata[MAN_W-1:0];
  assign w_frac_b = s_axis_b_tdata[MAN_W-1:0];

  // A zero exponent field covers both true zero and subnormals (DAZ).
  assign w_zero_a = (w_exp_a == '0);
  assign w_zero_b = (w_exp_b == '0);
  assign w_inf_a  = (&w_exp_a) && (w_frac_a == '0);
  assign w_inf_b  = (&w_exp_b) && (w_frac_b == '0);
  assign w_nan_a  = (&w_exp_a) && (w_frac_a != '0);
  assign w_nan_b  = (&w_exp_b) && (w_frac_b != '0);
  assign w_snan_a = w_nan_a && !w_frac_a[MAN_W-1];
  assign w_snan_b = w_nan_b && !w_frac_b[MAN_W-1];

  assign w_inf_zero = (w_inf_a && w_zero_b) || (w_inf_b && w_zero_a);
  assign w_nan      = w_nan_a || w_nan_b || w_inf_zero;
  assign w_invalid  = w_snan_a || w_snan_b || w_inf_zero;
  assign w_inf      = (w_inf_a || w_inf_b) && !w_nan;
  assign w_zero     = (w_zero_a || w_zero_b) && !w_nan && !w_inf;

  // Two guard bits on the exponent keep overflow and underflow distinguishable
  // as a positive-large or negative two's complement value.
  assign w_exp_sum = {2'b00, w_exp_a} + {2'b00, w_exp_b} - C_BIAS;
  assign w_prod    = C_PW'({1'b1, w_frac_a}) * C_PW'({1'b1, w_frac_b});

  logic             r1_sign, r1_nan, r1_invalid, r1_inf, r1_zero;
  logic [C_EW-1:0]  r1_exp;
  logic [C_PW-1:0]  r1_prod;

  // --------------------------------------------------------------------------
  // Stage 2 combinational: normalise (product lies in [1,4)) and round RNE
  // --------------------------------------------------------------------------
  logic             w_top;
  logic [MAN_W-1:0] w_frac_sel;
  logic             w_guard, w_sticky, w_round_up;
  logic             w_fcarry;
  logic [MAN_W-1:0] w_frac_rnd;
  logic [C_EW-1:0]  w_exp_rnd;

  assign w_top      = r1_prod[C_PW-1];
  assign w_frac_sel = w_top ? r1_prod[C_PW-2 -: MAN_W] : r1_prod[C_PW-3 -: MAN_W];
  assign w_guard    = w_top ? r1_prod[MAN_W] : r1_prod[MAN_W-1];
  assign w_sticky   = w_top ? (|r1_prod[MAN_W-1:0]) : (|r1_prod[MAN_W-2:0]);
  assign w_round_up = w_guard && (w_sticky || w_frac_sel[0]);

  // A carry out of the fraction leaves it wrapped to zero, which is exactly
  // the renormalised fraction; only the exponent needs the extra increment.
  assign {w_fcarry, w_frac_rnd} = {1'b0, w_frac_sel} + (MAN_W + 1)'(w_round_up);
  assign w_exp_rnd = r1_exp + C_EW'(w_top) + C_EW'(w_fcarry);

  logic             r2_sign, r2_nan, r2_invalid, r2_inf, r2_zero, r2_inexact;
  logic [C_EW-1:0]  r2_exp;
  logic [MAN_W-1:0] r2_frac;

  // --------------------------------------------------------------------------
  // Stage 3 combinational: special-case select and pack
  // --------------------------------------------------------------------------
  logic             w_ovf, w_unf;
  logic [C_DW-1:0]  w_out_data;
  logic [3:0]       w_out_user;

  assign w_ovf = !r2_exp[C_EW-1] && (r2_exp[C_EW-2:0] >= C_EXP_ONES);
  assign w_unf = r2_exp[C_EW-1] || (r2_exp == '0);

  always_comb begin
    w_out_data = {r2_sign, r2_exp[EXP_W-1:0], r2_frac};
    w_out_user = {3'b000, r2_inexact};
    if (r2_nan) begin
      w_out_data = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
      w_out_user = {r2_invalid, 3'b000};
    end else if (r2_inf) begin
      w_out_data = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_out_user = 4'b0000;
    end else if (r2_zero) begin
      w_out_data = {r2_sign, {(EXP_W + MAN_W){1'b0}}};
      w_out_user = 4'b0000;
    end else if (w_ovf) begin
      w_out_data = {r2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_out_user = 4'b0101;
    end else if (w_unf) begin
      w_out_data = {r2_sign, {(EXP_W + MAN_W){1'b0}}};
      w_out_user = 4'b0011;
    end
  end

  // --------------------------------------------------------------------------
  // Valid chain and output register (reset)
  // --------------------------------------------------------------------------
  logic            r_v1, r_v2, r_v3;
  logic [C_DW-1:0] r_out_data;
  logic [3:0]      r_out_user;

  always_ff @(posedge clock) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_out_data <= '0;
      r_out_user <= '0;
    end else if (w_adv) begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (r_v2) begin
        r_out_data <= w_out_data;
        r_out_user <= w_out_user;
      end
    end
  end

  // Stage datapath registers: qualified only by the valid chain, so no reset.
  always_ff @(posedge clock) begin
    if (w_adv) begin
      r1_sign    <= w_sign_a ^ w_sign_b;
      r1_nan     <= w_nan;
      r1_invalid <= w_invalid;
      r1_inf     <= w_inf;
      r1_zero    <= w_zero;
      r1_exp     <= w_exp_sum;
      r1_prod    <= w_prod;

      r2_sign    <= r1_sign;
      r2_nan     <= r1_nan;
      r2_invalid <= r1_invalid;
      r2_inf     <= r1_inf;
      r2_zero    <= r1_zero;
      r2_inexact <= w_guard || w_sticky;
      r2_exp     <= w_exp_rnd;
      r2_frac    <= w_frac_rnd;
    end
  end

  assign m_axis_result_tvalid = r_v3;
  assign m_axis_result_tdata  = r_out_data;
  assign m_axis_result_tuser  = r_out_user;

endmodule
`default_nettype wire
